// File: rtl/button_event.sv
// Button event decoder: turns a debounced button level into press, release, short-click,
// long-press and auto-repeat pulses, timed in units of an external tick strobe.
module button_event #(
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic short_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressed = 2'd1;
  localparam logic [1:0] StLong    = 2'd2;

  localparam logic [CNT_W-1:0] LongCnt   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] RepeatCnt = CNT_W'(REPEAT_TICKS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             btn_q;
  logic             rise, fall;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_comb begin
    rise      = btn & ~btn_q;
    fall      = ~btn & btn_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      StIdle: begin
        // A tick coincident with the rising edge is deliberately not counted.
        if (rise) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        // Release is checked first so it wins over a simultaneous terminal tick.
        if (fall) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (tick) begin
          if (cnt_inc == LongCnt) begin
            state_d = StLong;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StLong: begin
        if (fall) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (tick) begin
          if (cnt_inc == RepeatCnt) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: a hold-time model predicts every pulse each cycle,
// with literal spot checks on the key pulses of each scenario.
module tb_button_event;

  localparam int unsigned LongTicks   = 4;
  localparam int unsigned RepeatTicks = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic btn = 1'b0;
  logic press, release_pulse, short_click, long_press, repeat_pulse, held;

  int vectors = 0;
  int miscompares = 0;
  int n_press = 0, n_release = 0, n_short = 0, n_long = 0, n_repeat = 0;

  button_event #(
    .LONG_TICKS  (LongTicks),
    .REPEAT_TICKS(RepeatTicks),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btn          (btn),
    .press        (press),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Model: total ticks counted since the press decide every pulse.
  int   m_ticks = 0;
  bit   m_pressed = 1'b0;
  bit   m_btn_q = 1'b0;
  logic e_press = 1'b0, e_rel = 1'b0, e_short = 1'b0, e_long = 1'b0, e_rep = 1'b0;
  logic e_held = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ticks = 0; m_pressed = 1'b0; m_btn_q = 1'b0;
      e_press = 1'b0; e_rel = 1'b0; e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      e_held = 1'b0;
    end else begin
      e_press = 1'b0; e_rel = 1'b0; e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      if (!m_pressed) begin
        if (btn && !m_btn_q) begin
          m_pressed = 1'b1;
          m_ticks   = 0;
          e_press   = 1'b1;
        end
      end else if (!btn && m_btn_q) begin
        m_pressed = 1'b0;
        e_rel     = 1'b1;
        e_short   = (m_ticks < LongTicks);
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == LongTicks) e_long = 1'b1;
        else if (m_ticks > LongTicks && (m_ticks - LongTicks) % RepeatTicks == 0) e_rep = 1'b1;
      end
      e_held  = m_pressed;
      m_btn_q = btn;
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("press", press, e_press);
    cmp("release", release_pulse, e_rel);
    cmp("short_click", short_click, e_short);
    cmp("long_press", long_press, e_long);
    cmp("repeat", repeat_pulse, e_rep);
    cmp("held", held, e_held);
    cmp("pulse_exclusive",
        ((32'(press) + 32'(release_pulse) + 32'(long_press) + 32'(repeat_pulse)) > 1), 1'b0);
    cmp("short_without_release", short_click & ~release_pulse, 1'b0);
    n_press   += int'(press === 1'b1);
    n_release += int'(release_pulse === 1'b1);
    n_short   += int'(short_click === 1'b1);
    n_long    += int'(long_press === 1'b1);
    n_repeat  += int'(repeat_pulse === 1'b1);
  end

  task automatic cntchk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: count %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_repeat = 0;
  endtask

  // Apply inputs for one clock edge; returns at the following negedge with outputs settled.
  task automatic cyc(input logic b, input logic t);
    btn  = b;
    tick = t;
    @(negedge clk);
  endtask

  // One tick period: four quiet cycles then a tick cycle.
  task automatic tick_period(input logic b);
    for (int i = 0; i < 4; i++) cyc(b, 1'b0);
    cyc(b, 1'b1);
  endtask

  initial begin
    #2;
    cmp("reset_press", press, 1'b0);
    cmp("reset_held", held, 1'b0);
    cmp("reset_release", release_pulse, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Short click: 3 ticks then release.
    clr_counts();
    cyc(1'b1, 1'b0);
    cmp("sc_press", press, 1'b1);
    cmp("sc_held", held, 1'b1);
    for (int k = 0; k < 3; k++) tick_period(1'b1);
    cyc(1'b0, 1'b0);
    cmp("sc_release", release_pulse, 1'b1);
    cmp("sc_short", short_click, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    cntchk("sc_n_press", n_press, 1);
    cntchk("sc_n_short", n_short, 1);
    cntchk("sc_n_long", n_long, 0);

    // Long hold: 9 ticks.
    clr_counts();
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick_period(1'b1);
      if (k == 4) cmp("lh_long_after_tick4", long_press, 1'b1);
      if (k == 6 || k == 8) cmp("lh_repeat", repeat_pulse, 1'b1);
      if (k == 5 || k == 7 || k == 9) cmp("lh_no_repeat", repeat_pulse, 1'b0);
    end
    cyc(1'b0, 1'b0);
    cmp("lh_release", release_pulse, 1'b1);
    cmp("lh_no_short", short_click, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    cntchk("lh_n_long", n_long, 1);
    cntchk("lh_n_repeat", n_repeat, 2);

    // Race: falling edge on the 4th tick.
    clr_counts();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) tick_period(1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cmp("race_release", release_pulse, 1'b1);
    cmp("race_short", short_click, 1'b1);
    cmp("race_no_long", long_press, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
    cntchk("race_n_long", n_long, 0);

    // Tick coincident with the rising edge is ignored.
    clr_counts();
    cyc(1'b1, 1'b1);
    cmp("co_press", press, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick_period(1'b1);
      cmp("co_long", long_press, (k == 4));
    end
    cyc(1'b0, 1'b0);
    cmp("co_release", release_pulse, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

    // Reset mid-LONG with the button still down.
    clr_counts();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick_period(1'b1);
    cmp("rl_held_before", held, 1'b1);
    #2 rst = 1'b0;
    #1;
    cmp("rl_held_async", held, 1'b0);
    cmp("rl_release_async", release_pulse, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cntchk("rl_n_release", n_release, 0);
    cntchk("rl_n_short", n_short, 0);
    cyc(1'b1, 1'b0);
    cmp("rl_press_after_reset", press, 1'b1);
    cyc(1'b0, 1'b0);
    cmp("rl_release", release_pulse, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

    // No ticks: stays pressed indefinitely.
    clr_counts();
    for (int i = 0; i < 1000; i++) cyc(1'b1, 1'b0);
    cmp("nt_held", held, 1'b1);
    cntchk("nt_n_long", n_long, 0);
    cntchk("nt_n_repeat", n_repeat, 0);
    cyc(1'b0, 1'b0);
    cmp("nt_short", short_click, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter LONG_TICKS, default 1000, SHALL set the number of tick strobes the button must be held before long_press is generated.
REQ-003 Parameter REPEAT_TICKS, default 200, SHALL set the period in tick strobes between repeat pulses after long_press.
REQ-004 Parameter CNT_W, default 16, SHALL set the tick counter width and SHALL satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS); both tick parameters SHALL be >= 1.
REQ-005 clk  input  1  SHALL be the rising-edge system clock.
REQ-006 rst  input  1  SHALL be the asynchronous active-low reset.
REQ-007 tick  input  1  SHALL be a one-cycle time-base strobe from the timer prescaler (e.g. 1 kHz).
REQ-008 btn  input  1  SHALL be the debounced, clk-synchronous button level (1 = pressed).
REQ-009 press  output  1  SHALL be a one-cycle pulse on each press.
REQ-010 release  output  1  SHALL be a one-cycle pulse on each release.
REQ-011 short_click  output  1  SHALL be a one-cycle pulse on a release that occurs before long_press.
REQ-012 long_press  output  1  SHALL be a one-cycle pulse when the hold reaches LONG_TICKS.
REQ-013 repeat  output  1  SHALL be a one-cycle auto-repeat pulse while the hold continues past long_press.
REQ-014 held  output  1  SHALL be a level, high while the block is in PRESSED or LONG.

Function
REQ-015 All outputs SHALL be registered; no combinational path from btn or tick to any output.
REQ-016 The block SHALL keep a one-cycle-delayed copy btn_q of btn; a rising edge is btn=1 and btn_q=0, a falling edge is btn=0 and btn_q=1.
REQ-017 The FSM SHALL have exactly three states: IDLE, PRESSED, LONG.
REQ-018 IDLE: on a rising edge -> PRESSED, counter cleared to 0, press=1 and held=1 in the following cycle.
REQ-019 PRESSED: each cycle with tick=1 SHALL increment the counter; when a tick brings the count to LONG_TICKS -> LONG, counter cleared, long_press=1 in the following cycle.
REQ-020 LONG: each cycle with tick=1 SHALL increment the counter; when a tick brings the count to REPEAT_TICKS -> counter cleared, repeat=1 in the following cycle, state stays LONG.
REQ-021 PRESSED, falling edge -> IDLE, release=1 and short_click=1 in the following cycle, held=0.
REQ-022 LONG, falling edge -> IDLE, release=1 in the following cycle, short_click=0, held=0.
REQ-023 A tick in the same cycle as the rising edge SHALL NOT be counted.
REQ-024 Simultaneous falling edge and terminal tick: release SHALL win; PRESSED gives short_click without long_press, LONG gives release without repeat.
REQ-025 The counter SHALL never exceed max(LONG_TICKS, REPEAT_TICKS) and SHALL never wrap.
REQ-026 Latency from the btn sampling edge to press/release/short_click SHALL be exactly 1 cycle; from the terminal tick to long_press/repeat SHALL be exactly 1 cycle.
REQ-027 No two of press, release, long_press, repeat SHALL be high in the same cycle; short_click SHALL be high only together with release.
REQ-028 With tick held at 0, the block SHALL stay in PRESSED indefinitely and SHALL emit no long_press or repeat.

Reset
REQ-029 While rst=0, state SHALL be IDLE, counter=0, btn_q=0, and press, release, short_click, long_press, repeat, held SHALL all be 0, independent of clk.
REQ-030 Reset asserted mid-hold SHALL abort without any release or short_click pulse.
REQ-031 If btn=1 when rst deasserts, the first clock edge SHALL detect a rising edge and emit press in the following cycle.

Verification (bench parameters LONG_TICKS=4, REPEAT_TICKS=2, tick every 5 clk)
REQ-032 Short click: press held for 3 ticks then released -> press once, one release+short_click pulse, no long_press, held high for the whole hold.
REQ-033 Long hold: held for 9 ticks -> press, long_press 1 cycle after the 4th tick, repeat 1 cycle after ticks 6 and 8, release without short_click.
REQ-034 Race: falling edge in the same cycle as the 4th tick -> release+short_click, no long_press.
REQ-035 Tick coincident with the rising edge -> not counted; long_press follows the 4th later tick.
REQ-036 Reset mid-LONG: rst=0 for 2 cycles -> all outputs 0 immediately; btn still 1 at deassert -> press 1 cycle after the first clock edge.
REQ-037 tick=0 with btn held 1000 cycles -> held=1, no long_press or repeat; one-hot pulse check (REQ-027) asserted throughout every scenario.
